// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and default widths for the spiking neuron blocks
package snn_pkg;

  // Default widths, shared between the neuron and the STDP learning block
  localparam int SNN_W_WIDTH = 8;
  localparam int SNN_V_WIDTH = 16;

  // Neuron control states
  typedef enum logic [0:0] {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } lif_state_e;

  // Refractory timer width: must hold REFRACT_CYCLES-1, never narrower than 1 bit
  function automatic int timer_width(input int refract_cycles);
    return (refract_cycles > 1) ? $clog2(refract_cycles) : 1;
  endfunction

endpackage

// File: rtl/lif_integrator.sv
// rtl/lif_integrator.sv - combinational leak, synaptic add and threshold compare
module lif_integrator
  import snn_pkg::*;
#(
  parameter int W_WIDTH    = SNN_W_WIDTH,
  parameter int V_WIDTH    = SNN_V_WIDTH,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [V_WIDTH-1:0] v,
  input  logic               pre_spike,
  input  logic [W_WIDTH-1:0] weight,
  output logic [V_WIDTH:0]   sum,
  output logic               fire
);

  localparam logic [V_WIDTH:0] THR = (V_WIDTH + 1)'(THRESHOLD);

  logic [V_WIDTH-1:0] leak;
  logic [V_WIDTH:0]   add;

  // Leak is v >> LEAK_SHIFT, except LEAK_SHIFT==0 means no leak at all;
  // the extra sum bit absorbs a large weight added on top of v
  always_comb begin
    leak = (LEAK_SHIFT == 0) ? '0 : (v >> LEAK_SHIFT);
    add  = pre_spike ? (V_WIDTH + 1)'(weight) : '0;
    sum  = {1'b0, v} - {1'b0, leak} + add;
    fire = (sum >= THR);
  end

endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory period
module lif_neuron
  import snn_pkg::*;
#(
  parameter int W_WIDTH        = SNN_W_WIDTH,
  parameter int V_WIDTH        = SNN_V_WIDTH,
  parameter int THRESHOLD      = 100,
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               pre_spike,
  input  logic [W_WIDTH-1:0] weight,
  output logic               post_spike,
  output logic [V_WIDTH-1:0] membrane,
  output logic               refractory,
  output logic [7:0]         spike_count
);

  localparam int TIMER_W = timer_width(REFRACT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD =
    (REFRACT_CYCLES > 0) ? TIMER_W'(REFRACT_CYCLES - 1) : '0;

  // A threshold of zero or one the membrane can never reach is a build error
  if (THRESHOLD < 1 || longint'(THRESHOLD) > ((longint'(1) << V_WIDTH) - 1)) begin : g_threshold_check
    $fatal(1, "lif_neuron: THRESHOLD out of range 1..2^V_WIDTH-1");
  end

  lif_state_e         state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [V_WIDTH-1:0] membrane_next;
  logic               post_next;
  logic [7:0]         count_next;
  logic [V_WIDTH:0]   sum;
  logic               fire;
  logic               crossed;

  lif_integrator #(
    .W_WIDTH    (W_WIDTH),
    .V_WIDTH    (V_WIDTH),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_integrator (
    .v         (membrane),
    .pre_spike (pre_spike),
    .weight    (weight),
    .sum       (sum),
    .fire      (fire)
  );

  // A carry into the top sum bit is always above any legal threshold
  assign crossed    = fire | sum[V_WIDTH];
  assign refractory = (state == ST_REFRACT);

  // Next-state logic: en=0 holds everything and squashes the spike pulse
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    membrane_next = membrane;
    post_next     = 1'b0;
    count_next    = spike_count;
    if (en) begin
      case (state)
        ST_INTEGRATE: begin
          if (crossed) begin
            membrane_next = '0;
            post_next     = 1'b1;
            count_next    = spike_count + 8'd1;
            if (REFRACT_CYCLES > 0) begin
              timer_next = TIMER_LOAD;
              state_next = ST_REFRACT;
            end
          end else begin
            membrane_next = sum[V_WIDTH-1:0];
          end
        end
        ST_REFRACT: begin
          membrane_next = '0;
          if (timer == '0) begin
            state_next = ST_INTEGRATE;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
        default: begin
          state_next = ST_INTEGRATE;
        end
      endcase
    end
  end

  // State and output registers; reset overrides enable and refractory
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INTEGRATE;
      timer       <= '0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      membrane    <= membrane_next;
      post_spike  <= post_next;
      spike_count <= count_next;
    end
  end

endmodule
